onewire_rom_rx: RTL and testbench

//  Receive side of the 1-Wire ROM-ID path. Accepts the 64-bit ROM code one bit at a time

---
 rtl/onewire_rom_rx_if.sv | 31 +++
 rtl/onewire_rom_rx.sv | 174 +++++++++++++++++
 tb/tb_onewire_rom_rx.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onewire_rom_rx_if.sv
// Bus between the 1-Wire bit-slot layer / search controller and the ROM-ID receiver.
// master: controller side (drives start/abort/bit strobe, reads results).
// slave : receiver side (onewire_rom_rx).
//   start, abort, bit_valid, bit_in : controller -> receiver
//   busy, done, crc_ok, timeout_err : receiver status
//   rom_code[63:0], bit_cnt[6:0]    : captured code and accepted-bit count
interface onewire_rom_rx_if;
  localparam int unsigned CODE_W = 64;
  localparam int unsigned CNT_W  = 7;

  logic              start;
  logic              abort;
  logic              bit_valid;
  logic              bit_in;
  logic              busy;
  logic              done;
  logic              crc_ok;
  logic [CODE_W-1:0] rom_code;
  logic [CNT_W-1:0]  bit_cnt;
  logic              timeout_err;

  modport master (
    output start, abort, bit_valid, bit_in,
    input  busy, done, crc_ok, rom_code, bit_cnt, timeout_err
  );

  modport slave (
    input  start, abort, bit_valid, bit_in,
    output busy, done, crc_ok, rom_code, bit_cnt, timeout_err
  );
endinterface

// File: rtl/onewire_rom_rx.sv
// 1-Wire ROM-ID receiver: assembles the 64-bit ROM code LSB-first from the bit-slot
// layer, runs the Dallas/Maxim CRC8 (x^8+x^5+x^4+1) serially over all 64 bits and
// reports the code plus a pass/fail flag.
// Optional feature macro: ONEWIRE_RX_TIMEOUT_EN (inter-bit timeout, TIMEOUT_CYCLES).
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   rx   : onewire_rom_rx_if.slave (start/abort/bit_valid/bit_in in;
//          busy/done/crc_ok/rom_code/bit_cnt/timeout_err out, all registered)
module onewire_rom_rx #(
  parameter bit REJECT_ZERO = 1'b1
`ifdef ONEWIRE_RX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 50000
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  onewire_rom_rx_if.slave      rx
);

  localparam int unsigned CODE_W   = 64;
  localparam int unsigned CNT_W    = 7;
  localparam int unsigned CRC_W    = 8;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CODE_W - 1);
  localparam logic [CRC_W-1:0] CRC_POLY = 8'h8C;  // reflected x^8+x^5+x^4+1

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   rom_q, rom_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                crc_ok_q, crc_ok_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fb;

`ifdef ONEWIRE_RX_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                tmo_err_q, tmo_err_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rom_q     <= '0;
      crc_q     <= '0;
      cnt_q     <= '0;
      crc_ok_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ONEWIRE_RX_TIMEOUT_EN
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rom_q     <= rom_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      crc_ok_q  <= crc_ok_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef ONEWIRE_RX_TIMEOUT_EN
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
`endif
    end
  end

  // Next-state, shift/CRC datapath and registered-output next values
  always_comb begin
    state_d   = state_q;
    rom_d     = rom_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    crc_ok_d  = crc_ok_q;
    fb        = 1'b0;
`ifdef ONEWIRE_RX_TIMEOUT_EN
    tmo_d     = tmo_q;
    tmo_err_d = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // abort outranks a simultaneous start
        if (rx.start && !rx.abort) begin
          state_d  = ST_RECV;
          rom_d    = '0;
          crc_d    = '0;
          cnt_d    = '0;
          crc_ok_d = 1'b0;
`ifdef ONEWIRE_RX_TIMEOUT_EN
          tmo_d    = '0;
`endif
        end
      end

      ST_RECV: begin
        if (rx.abort) begin
          // partial code is left in rom_q for debug
          state_d  = ST_IDLE;
          crc_ok_d = 1'b0;
        end else if (rx.bit_valid) begin
          rom_d = {rx.bit_in, rom_q[CODE_W-1:1]};
          fb    = crc_q[0] ^ rx.bit_in;
          crc_d = {1'b0, crc_q[CRC_W-1:1]} ^ (fb ? CRC_POLY : '0);
          cnt_d = cnt_q + CNT_W'(1);
`ifdef ONEWIRE_RX_TIMEOUT_EN
          tmo_d = '0;
`endif
          if (cnt_q == LAST_BIT) begin
            state_d = ST_CHECK;
          end
        end
`ifdef ONEWIRE_RX_TIMEOUT_EN
        // a bit arriving on the expiry cycle wins (handled above)
        else if (tmo_q == TMO_LAST) begin
          state_d   = ST_IDLE;
          crc_ok_d  = 1'b0;
          tmo_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end

      ST_CHECK: begin
        if (rx.abort) begin
          state_d  = ST_IDLE;
          crc_ok_d = 1'b0;
        end else begin
          // all-zero code has a zero residue, so it is rejected explicitly
          crc_ok_d = (crc_q == '0) && !(REJECT_ZERO && (rom_q == '0));
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RECV) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  assign rx.busy     = busy_q;
  assign rx.done     = done_q;
  assign rx.crc_ok   = crc_ok_q;
  assign rx.rom_code = rom_q;
  assign rx.bit_cnt  = cnt_q;

`ifdef ONEWIRE_RX_TIMEOUT_EN
  assign rx.timeout_err = tmo_err_q;
`else
  assign rx.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_onewire_rom_rx.sv
// Self-checking bench for onewire_rom_rx. A second instance with REJECT_ZERO=0 shares
// the stimulus. Expected frame results are queued when a frame is sent and compared
// when done pulses. Define ONEWIRE_RX_TIMEOUT_EN to exercise the inter-bit timeout.
module tb_onewire_rom_rx;

  localparam logic [63:0] GOLDEN = 64'hA200_0000_01B8_1C02;
  localparam logic [63:0] BADCRC = 64'h2200_0000_01B8_1C02;

  typedef struct packed {
    logic [63:0] code;
    logic        ok;
    logic        ok_nz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  onewire_rom_rx_if rx_if ();
  onewire_rom_rx_if nz_if ();

  assign nz_if.start     = rx_if.start;
  assign nz_if.abort     = rx_if.abort;
  assign nz_if.bit_valid = rx_if.bit_valid;
  assign nz_if.bit_in    = rx_if.bit_in;

  onewire_rom_rx #(
    .REJECT_ZERO(1'b1)
`ifdef ONEWIRE_RX_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx (rx_if)
  );

  onewire_rom_rx #(
    .REJECT_ZERO(1'b0)
`ifdef ONEWIRE_RX_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut_nz (
    .clk(clk),
    .rst(rst),
    .rx (nz_if)
  );

  int   checks   = 0;
  int   failures = 0;
  int   pushes   = 0;
  int   dones    = 0;
  int   tmo_seen = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent byte-wise Maxim CRC8 over the 56 payload bits
  function automatic logic [7:0] crc8_bytes(input logic [55:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int b = 0; b < 7; b++) begin
      c = c ^ d[b*8 +: 8];
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  // Scoreboard: compare each done against the oldest queued frame
  always @(negedge clk) begin
    if (!rst && rx_if.done) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        dones++;
        check_eq("sb_rom_code", rx_if.rom_code, mon_e.code);
        check_eq("sb_crc_ok", rx_if.crc_ok, mon_e.ok);
        check_eq("sb_crc_ok_nz", nz_if.crc_ok, mon_e.ok_nz);
        check_eq("sb_bit_cnt", rx_if.bit_cnt, 64'd64);
        check_eq("sb_nz_done", nz_if.done, 1);
      end
    end
    if (!rst && rx_if.timeout_err) tmo_seen++;
  end

  task automatic pulse_start();
    rx_if.start = 1'b1;
    @(negedge clk);
    rx_if.start = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] code, input int lo, input int hi, input int gap);
    for (int i = lo; i <= hi; i++) begin
      rx_if.bit_valid = 1'b1;
      rx_if.bit_in    = code[i];
      @(negedge clk);
      rx_if.bit_valid = 1'b0;
      rx_if.bit_in    = 1'b0;
      if (i < hi) repeat (gap) @(negedge clk);
    end
  endtask

  // Called at the first negedge after bit 64 was accepted
  task automatic finish_frame(input logic [63:0] code, input logic ok, input logic ok_nz,
                              input string tag);
    exp_t e;
    e.code  = code;
    e.ok    = ok;
    e.ok_nz = ok_nz;
    exp_q.push_back(e);
    pushes++;
    check_eq({tag, "_lat1_done"}, rx_if.done, 0);
    check_eq({tag, "_lat1_busy"}, rx_if.busy, 1);
    @(negedge clk);
    check_eq({tag, "_lat2_done"}, rx_if.done, 1);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, rx_if.done, 0);
    check_eq({tag, "_idle_busy"}, rx_if.busy, 0);
    check_eq({tag, "_hold_code"}, rx_if.rom_code, code);
    check_eq({tag, "_hold_ok"}, rx_if.crc_ok, ok);
  endtask

  task automatic run_frame(input logic [63:0] code, input logic ok, input logic ok_nz,
                           input string tag);
    pulse_start();
    check_eq({tag, "_busy"}, rx_if.busy, 1);
    check_eq({tag, "_cnt0"}, rx_if.bit_cnt, 0);
    send_bits(code, 0, 63, 0);
    finish_frame(code, ok, ok_nz, tag);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, rx_if.busy, 0);
    check_eq({tag, "_done"}, rx_if.done, 0);
    check_eq({tag, "_crc_ok"}, rx_if.crc_ok, 0);
    check_eq({tag, "_rom_code"}, rx_if.rom_code, 0);
    check_eq({tag, "_bit_cnt"}, rx_if.bit_cnt, 0);
    check_eq({tag, "_tmo"}, rx_if.timeout_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] g;
    logic [55:0] r;
    logic [63:0] code;
    int          wait_cnt;
    bit          seen;

    g               = GOLDEN;
    rst             = 1'b1;
    rx_if.start     = 1'b0;
    rx_if.abort     = 1'b0;
    rx_if.bit_valid = 1'b0;
    rx_if.bit_in    = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Stray bits in IDLE are ignored
    rx_if.bit_valid = 1'b1;
    rx_if.bit_in    = 1'b1;
    repeat (3) @(negedge clk);
    rx_if.bit_valid = 1'b0;
    check_eq("stray_bit_cnt", rx_if.bit_cnt, 0);
    check_eq("stray_busy", rx_if.busy, 0);

    // start with abort in IDLE: abort wins
    rx_if.start = 1'b1;
    rx_if.abort = 1'b1;
    @(negedge clk);
    rx_if.start = 1'b0;
    rx_if.abort = 1'b0;
    check_eq("start_abort_busy", rx_if.busy, 0);

    // T1 golden code
    run_frame(GOLDEN, 1'b1, 1'b1, "golden");

    // Random frames with valid CRC byte
    for (int n = 0; n < 3; n++) begin
      r    = 56'({$urandom(), $urandom()});
      code = {crc8_bytes(r), r};
      run_frame(code, 1'b1, 1'b1, "rand");
    end

    // T2 bad CRC, T3 all-zero
    run_frame(BADCRC, 1'b0, 1'b0, "badcrc");
    run_frame(64'd0, 1'b0, 1'b1, "zero");

    // T4 abort after 20 bits, abort beats a simultaneous bit
    pulse_start();
    send_bits(GOLDEN, 0, 19, 0);
    rx_if.abort     = 1'b1;
    rx_if.bit_valid = 1'b1;
    rx_if.bit_in    = 1'b1;
    @(negedge clk);
    rx_if.abort     = 1'b0;
    rx_if.bit_valid = 1'b0;
    rx_if.bit_in    = 1'b0;
    check_eq("abort_busy", rx_if.busy, 0);
    check_eq("abort_crc_ok", rx_if.crc_ok, 0);
    check_eq("abort_bit_cnt", rx_if.bit_cnt, 20);
    check_eq("abort_partial", 64'(rx_if.rom_code[63:44]), 64'(g[19:0]));
    repeat (4) @(negedge clk);
    run_frame(GOLDEN, 1'b1, 1'b1, "after_abort");

    // Abort during CHECK: no done
    pulse_start();
    send_bits(GOLDEN, 0, 63, 0);
    rx_if.abort = 1'b1;
    @(negedge clk);
    rx_if.abort = 1'b0;
    check_eq("abort_chk_busy", rx_if.busy, 0);
    check_eq("abort_chk_done", rx_if.done, 0);
    check_eq("abort_chk_crc_ok", rx_if.crc_ok, 0);
    repeat (3) @(negedge clk);

    // start during RECV does not restart
    pulse_start();
    send_bits(GOLDEN, 0, 9, 0);
    pulse_start();
    check_eq("restart_bit_cnt", rx_if.bit_cnt, 10);
    check_eq("restart_busy", rx_if.busy, 1);
    send_bits(GOLDEN, 10, 63, 0);
    finish_frame(GOLDEN, 1'b1, 1'b1, "restart");

    // T5 reset at bit 40
    pulse_start();
    send_bits(GOLDEN, 0, 38, 0);
    rst             = 1'b1;
    rx_if.bit_valid = 1'b1;
    rx_if.bit_in    = g[39];
    @(negedge clk);
    rx_if.bit_valid = 1'b0;
    check_all_zero("midrst");
    rst = 1'b0;
    @(negedge clk);

`ifdef ONEWIRE_RX_TIMEOUT_EN
    // T6 idle gap after 10 bits -> timeout 16 cycles after the last bit
    pulse_start();
    send_bits(GOLDEN, 0, 9, 0);
    wait_cnt = 0;
    seen     = 1'b0;
    while (!seen && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
      if (rx_if.timeout_err) seen = 1'b1;
    end
    check_eq("tmo_seen", 64'(seen), 64'd1);
    check_eq("tmo_latency", 64'(wait_cnt), 64'd16);
    check_eq("tmo_busy", rx_if.busy, 0);
    check_eq("tmo_crc_ok", rx_if.crc_ok, 0);
    @(negedge clk);
    check_eq("tmo_pulse", rx_if.timeout_err, 0);
    // 15 idle cycles between bits never expires
    pulse_start();
    send_bits(GOLDEN, 0, 63, 15);
    finish_frame(GOLDEN, 1'b1, 1'b1, "gap15");
    check_eq("tmo_total", 64'(tmo_seen), 64'd1);
`else
    // Without the timeout, a long gap just waits
    pulse_start();
    send_bits(GOLDEN, 0, 9, 0);
    repeat (200) @(negedge clk);
    check_eq("notmo_busy", rx_if.busy, 1);
    check_eq("notmo_cnt", rx_if.bit_cnt, 10);
    send_bits(GOLDEN, 10, 63, 0);
    finish_frame(GOLDEN, 1'b1, 1'b1, "longgap");
    check_eq("tmo_total", 64'(tmo_seen), 64'd0);
`endif

    repeat (5) @(negedge clk);
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    check_eq("sb_done_count", 64'(dones), 64'(pushes));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
